serial_alu_controller: RTL and testbench

SERIAL_ALU_CONTROLLER -- requirements
Module: serial_alu_controller

---
 rtl/serial_alu_controller_pkg.sv | 35 +++
 rtl/serial_alu_controller_one_bit_alu.sv | 47 ++++
 rtl/serial_alu_controller.sv | 158 +++++++++++++++
 tb/tb_serial_alu_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_alu_controller_pkg.sv
// Shared definitions for the bit-serial ALU controller and its one-bit ALU.
//   CONTROL_WIDTH / MUX_WIDTH : control word and mux select widths
//   F0..F4                    : bit positions inside the control word
//   SEL_*                     : mux select codes (5..7 are illegal)
//   state_t                   : controller FSM state encoding
//   sel_is_legal()            : true for select codes 0..4
package serial_alu_controller_pkg;

    localparam int CONTROL_WIDTH = 5;
    localparam int MUX_WIDTH     = 3;

    // Control word layout: [2:0] select, [3] B enable, [4] A invert.
    localparam int F0 = 0;
    localparam int F1 = 1;
    localparam int F2 = 2;
    localparam int F3 = 3;
    localparam int F4 = 4;

    localparam logic [MUX_WIDTH-1:0] SEL_AND = 3'd0;
    localparam logic [MUX_WIDTH-1:0] SEL_OR  = 3'd1;
    localparam logic [MUX_WIDTH-1:0] SEL_XOR = 3'd2;
    localparam logic [MUX_WIDTH-1:0] SEL_ADD = 3'd3;
    localparam logic [MUX_WIDTH-1:0] SEL_SUB = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic sel_is_legal(input logic [MUX_WIDTH-1:0] sel);
        return sel <= SEL_SUB;
    endfunction

endpackage

// File: rtl/serial_alu_controller_one_bit_alu.sv
// One-bit ALU slice used once per clock by the serial controller.
//   a, b        : operand bits (before A invert / B enable are applied)
//   carry_in    : carry from the previous bit
//   borrow_in   : borrow from the previous bit
//   f           : control word (select, B enable, A invert)
//   y           : result bit for the selected operation (0 for illegal selects)
//   carry_out   : full-adder carry, produced for every select
//   borrow_out  : full-subtractor borrow, produced for every select
module one_bit_alu
    import serial_alu_controller_pkg::*;
(
    input  logic                     a,
    input  logic                     b,
    input  logic                     carry_in,
    input  logic                     borrow_in,
    input  logic [CONTROL_WIDTH-1:0] f,
    output logic                     y,
    output logic                     carry_out,
    output logic                     borrow_out
);

    logic a_eff;
    logic b_eff;
    logic sum;
    logic diff;

    assign a_eff = f[F4] ? ~a : a;
    assign b_eff = f[F3] ? b : 1'b0;

    assign sum        = a_eff ^ b_eff ^ carry_in;
    assign carry_out  = (a_eff & b_eff) | (carry_in & (a_eff ^ b_eff));
    assign diff       = a_eff ^ b_eff ^ borrow_in;
    assign borrow_out = (~a_eff & b_eff) | (~(a_eff ^ b_eff) & borrow_in);

    always_comb begin
        y = 1'b0;
        case (f[F2:F0])
            SEL_AND: y = a_eff & b_eff;
            SEL_OR:  y = a_eff | b_eff;
            SEL_XOR: y = a_eff ^ b_eff;
            SEL_ADD: y = sum;
            SEL_SUB: y = diff;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_controller.sv
// Bit-serial ALU controller: runs one WIDTH-bit operation LSB first through a
// single one_bit_alu, one bit per clock.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i, f_i        : start request and control word (sampled in IDLE only)
//   a_i, b_i            : operands, captured on an accepted start
//   busy_o              : high in RUN and DONE
//   done_o              : one-cycle pulse; result_o/carry_o/borrow_o valid
//   err_o               : one-cycle pulse after a start with an illegal select
//   result_o, carry_o,
//   borrow_o            : outputs of the last completed operation (held)
//   state_o             : current FSM state, for observation
//
// Handshake: start_i is a request, not a valid/ready pair. It is accepted only
// when busy_o is low (IDLE) and the select is legal; while busy_o is high it is
// dropped, never queued. done_o marks the single cycle in which new results
// first appear; the next start may be accepted in the cycle after done_o.
module serial_alu_controller
    import serial_alu_controller_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [CONTROL_WIDTH-1:0] f_i,
    input  logic [WIDTH-1:0]         a_i,
    input  logic [WIDTH-1:0]         b_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [WIDTH-1:0]         result_o,
    output logic                     carry_o,
    output logic                     borrow_o,
    output state_t                   state_o
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [WIDTH-1:0]         a_q;
    logic [WIDTH-1:0]         b_q;
    logic [CONTROL_WIDTH-1:0] f_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     carry_q;
    logic                     borrow_q;
    logic [WIDTH-1:0]         shift_q;
    logic [WIDTH-1:0]         shift_next;
    logic [WIDTH-1:0]         result_q;
    logic                     carry_out_q;
    logic                     borrow_out_q;
    logic                     err_q;

    logic alu_y;
    logic alu_carry;
    logic alu_borrow;
    logic accept;
    logic last_bit;

    one_bit_alu u_alu (
        .a          (a_q[cnt_q]),
        .b          (b_q[cnt_q]),
        .carry_in   (carry_q),
        .borrow_in  (borrow_q),
        .f          (f_q),
        .y          (alu_y),
        .carry_out  (alu_carry),
        .borrow_out (alu_borrow)
    );

    assign accept   = (state_q == ST_IDLE) && start_i && sel_is_legal(f_i[F2:F0]);
    assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

    always_comb begin
        shift_next        = shift_q;
        shift_next[cnt_q] = alu_y;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            ST_RUN:  busy_o = 1'b1;
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, serial shift, flags and held outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
            shift_q      <= '0;
            result_q     <= '0;
            carry_out_q  <= 1'b0;
            borrow_out_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && start_i && !sel_is_legal(f_i[F2:F0]);
            if (accept) begin
                a_q      <= a_i;
                b_q      <= b_i;
                f_q      <= f_i;
                cnt_q    <= '0;
                carry_q  <= 1'b0;
                borrow_q <= 1'b0;
            end else if (state_q == ST_RUN) begin
                shift_q  <= shift_next;
                carry_q  <= alu_carry;
                borrow_q <= alu_borrow;
                // Counter parks at the terminal count instead of wrapping.
                if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
            end
            // Outputs load on the edge entering DONE so they are already valid
            // while done_o is high; they carry the same values the shift
            // register and flags hold during DONE.
            if (last_bit) begin
                result_q     <= shift_next;
                carry_out_q  <= alu_carry;
                borrow_out_q <= alu_borrow;
            end
        end
    end

    assign err_o    = err_q;
    assign result_o = result_q;
    assign carry_o  = carry_out_q;
    assign borrow_o = borrow_out_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_serial_alu_controller.sv
module tb_serial_alu_controller;
    import serial_alu_controller_pkg::*;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  f_in = '0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  result;
    logic        carry;
    logic        borrow;
    state_t      st;

    int n_cmp = 0;
    int n_bad = 0;

    serial_alu_controller #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .f_i      (f_in),
        .a_i      (a_in),
        .b_i      (b_in),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .result_o (result),
        .carry_o  (carry),
        .borrow_o (borrow),
        .state_o  (st)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Drives a start for one cycle, then waits (bounded)
    // for done_o. lat counts edges from the one sampling start to done_o.
    task automatic run_op(input logic [4:0] f, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        start = 1'b1; f_in = f; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_err",    err,    0);
        check("rst_result", result, 0);
        check("rst_carry",  carry,  0);
        check("rst_borrow", borrow, 0);
        check("rst_state",  32'(st), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // ADD 0xFF + 0x01
        run_op(5'h0B, 8'hFF, 8'h01, lat);
        check("add_lat",    lat,    9);
        check("add_busy",   busy,   1);
        check("add_result", result, 8'h00);
        check("add_carry",  carry,  1);
        @(negedge clk);
        check("add_done_pulse", done,   0);
        check("add_idle_busy",  busy,   0);
        check("add_hold",       result, 8'h00);

        // SUB 5 - 10, then back-to-back SUB 10 - 5
        run_op(5'h0C, 8'h05, 8'h0A, lat);
        check("sub1_lat",    lat,    9);
        check("sub1_result", result, 8'hFB);
        check("sub1_borrow", borrow, 1);
        @(negedge clk);
        run_op(5'h0C, 8'h0A, 8'h05, lat);
        check("sub2_lat",    lat,    9);
        check("sub2_result", result, 8'h05);
        check("sub2_borrow", borrow, 0);
        @(negedge clk);

        // AND with A invert: ~0xF0 & 0x3C
        run_op(5'h18, 8'hF0, 8'h3C, lat);
        check("andinv_result", result, 8'h0C);
        @(negedge clk);

        // ADD with B disabled: 0x12 + 0
        run_op(5'h03, 8'h12, 8'hFF, lat);
        check("addnob_result", result, 8'h12);
        check("addnob_carry",  carry,  0);
        @(negedge clk);

        // Start during RUN with different operands is ignored: 0x01 + 0x02
        ndone = 0;
        start = 1'b1; f_in = 5'h0B; a_in = 8'h01; b_in = 8'h02;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin
                start = 1'b1; f_in = 5'h0A; a_in = 8'h40; b_in = 8'h40;
            end
            if (done) begin
                ndone++;
                check("ign_result", result, 8'h03);
                check("ign_carry",  carry,  0);
            end
        end
        start = 1'b0;
        check("ign_done_count", ndone, 1);
        check("ign_final_busy", busy,  0);

        // Illegal select 5
        start = 1'b1; f_in = 5'h0D; a_in = 8'h55; b_in = 8'h66;
        @(negedge clk);
        start = 1'b0;
        check("ill_err",  err,  1);
        check("ill_busy", busy, 0);
        @(negedge clk);
        check("ill_err_pulse", err,    0);
        check("ill_busy2",     busy,   0);
        check("ill_result",    result, 8'h03);

        // Reset at bit 4 of an ADD
        start = 1'b1; f_in = 5'h0B; a_in = 8'h0F; b_in = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy",   busy,   0);
        check("abort_result", result, 0);
        check("abort_state",  32'(st), 32'(ST_IDLE));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_done", done, 0);
        end
        check("abort_carry",  carry,  0);
        check("abort_borrow", borrow, 0);
        check("abort_err",    err,    0);
        rst = 1'b0;
        run_op(5'h0A, 8'hAA, 8'h0F, lat);
        check("xor_lat",    lat,    9);
        check("xor_result", result, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
